// File: rtl/id_regfile_sb.sv
// ID-stage integer register file: NREAD combinational read ports, NWRITE write-back
// ports with same-cycle bypass, hardwired x0, and a per-register pending-write scoreboard.
module id_regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1,
  parameter int unsigned PEND_W = 2,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*AW-1:0]     rd_addr,
  input  logic [NREAD-1:0]        rd_used,
  output logic [NREAD*XLEN-1:0]   rd_data,
  input  logic [NWRITE-1:0]       wr_en,
  input  logic [NWRITE*AW-1:0]    wr_addr,
  input  logic [NWRITE*XLEN-1:0]  wr_data,
  input  logic                    issue_valid,
  input  logic                    issue_wen,
  input  logic [AW-1:0]           issue_rd,
  input  logic                    flush,
  output logic                    stall,
  output logic                    err
);

  localparam int unsigned RW = $clog2(NWRITE + 1);
  localparam int unsigned CW = ((PEND_W > RW) ? PEND_W : RW) + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [XLEN-1:0]   regs     [1:NREG-1];
  logic [PEND_W-1:0] pend     [1:NREG-1];
  logic [PEND_W-1:0] pend_nxt [1:NREG-1];
  logic [PEND_W-1:0] pend_v   [NREG];
  logic [RW-1:0]     ret      [NREG];
  logic [NREAD-1:0]  src_busy;
  logic              full;
  logic              fire;
  logic              uf;

  // Pending view with x0 pinned to zero, and per-register retirement count this cycle
  always_comb begin
    pend_v[0] = '0;
    for (int r = 1; r < NREG; r++) pend_v[r] = pend[r];
    for (int r = 0; r < NREG; r++) begin
      ret[r] = '0;
      for (int w = 0; w < NWRITE; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(r)) ret[r] = ret[r] + RW'(1);
    end
  end

  // Read ports: later write ports override earlier ones in the bypass
  always_comb begin
    logic [AW-1:0] ra;
    ra      = '0;
    rd_data = '0;
    for (int i = 0; i < NREAD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (ra != '0) begin
        rd_data[i*XLEN +: XLEN] = regs[ra];
        for (int w = 0; w < NWRITE; w++)
          if (wr_en[w] && wr_addr[w*AW +: AW] == ra)
            rd_data[i*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
      end
    end
  end

  // Hazard detection; a source is free once this cycle's retirements cover all pending writes
  always_comb begin
    logic [AW-1:0] sa;
    sa       = '0;
    src_busy = '0;
    for (int i = 0; i < NREAD; i++) begin
      sa          = rd_addr[i*AW +: AW];
      src_busy[i] = rd_used[i] && (sa != '0) && (CW'(pend_v[sa]) > CW'(ret[sa]));
    end
    full  = issue_wen && (issue_rd != '0) && (pend_v[issue_rd] == PEND_MAX) &&
            (ret[issue_rd] == '0);
    stall = issue_valid && ((|src_busy) || full);
    fire  = issue_valid && !stall && !flush;
  end

  // Counter next state; over-retirement clamps at zero and flags underflow
  always_comb begin
    logic [CW-1:0] sum;
    sum = '0;
    uf  = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      sum = CW'(pend[r]) + CW'(fire && issue_wen && (issue_rd == AW'(r)));
      if (CW'(ret[r]) > sum) begin
        pend_nxt[r] = '0;
        uf          = 1'b1;
      end else begin
        pend_nxt[r] = PEND_W'(sum - CW'(ret[r]));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 1; r < NREG; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
      err <= 1'b0;
    end else begin
      for (int w = 0; w < NWRITE; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] != '0)
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
      for (int r = 1; r < NREG; r++) pend[r] <= flush ? '0 : pend_nxt[r];
      if (!flush && uf) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_regfile_sb.sv
// Scoreboard bench for id_regfile_sb: a driver pushes model-predicted responses per cycle,
// a monitor pops and compares them against the DUT at the falling edge.
module tb_id_regfile_sb;
  localparam int unsigned XLEN = 32, NREG = 32, NREAD = 2, NWRITE = 2, PEND_W = 2, AW = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREAD*AW-1:0]    rd_addr;
  logic [NREAD-1:0]       rd_used;
  logic [NREAD*XLEN-1:0]  rd_data;
  logic [NWRITE-1:0]      wr_en;
  logic [NWRITE*AW-1:0]   wr_addr;
  logic [NWRITE*XLEN-1:0] wr_data;
  logic                   issue_valid, issue_wen, flush, stall, err;
  logic [AW-1:0]          issue_rd;

  id_regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .NWRITE(NWRITE), .PEND_W(PEND_W)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_used(rd_used), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
    .issue_wen(issue_wen), .issue_rd(issue_rd), .flush(flush), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d0; logic [31:0] d1; logic st; logic er; } exp_t;
  exp_t  q[$];
  string tq[$];
  int    checks = 0, errors = 0;

  // Architectural model: register values, outstanding write counts, sticky error
  bit [31:0] m_mem [NREG];
  int        m_pend[NREG];
  bit        m_err;
  localparam int PMAX = (1 << PEND_W) - 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic cyc(input string tag, input bit r, input bit [1:0] we,
                     input int wa0, input int wa1, input bit [31:0] wd0, input bit [31:0] wd1,
                     input int ra0, input int ra1, input bit [1:0] used,
                     input bit iv, input bit iw, input int ird, input bit fl);
    exp_t      e;
    int        ret[NREG];
    int        wa[2], ra[2];
    bit [31:0] wd[2];
    bit        busy, full, st;
    @(posedge clk); #1;
    rst = r; wr_en = we; wr_addr = {AW'(wa1), AW'(wa0)}; wr_data = {wd1, wd0};
    rd_addr = {AW'(ra1), AW'(ra0)}; rd_used = used;
    issue_valid = iv; issue_wen = iw; issue_rd = AW'(ird); flush = fl;
    if (!r) begin
      for (int k = 0; k < NREG; k++) begin m_mem[k] = 0; m_pend[k] = 0; end
      m_err = 0;
    end
    wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
    for (int k = 0; k < NREG; k++) ret[k] = 0;
    for (int w = 0; w < 2; w++) if (we[w]) ret[wa[w]]++;
    busy = 0;
    for (int i = 0; i < 2; i++) begin
      if (used[i] && ra[i] != 0 && m_pend[ra[i]] > ret[ra[i]]) busy = 1;
    end
    e.d0 = (ra0 == 0) ? 32'h0 : m_mem[ra0];
    e.d1 = (ra1 == 0) ? 32'h0 : m_mem[ra1];
    for (int w = 0; w < 2; w++) begin
      if (we[w] && wa[w] == ra0 && ra0 != 0) e.d0 = wd[w];
      if (we[w] && wa[w] == ra1 && ra1 != 0) e.d1 = wd[w];
    end
    full = iw && ird != 0 && m_pend[ird] == PMAX && ret[ird] == 0;
    st   = iv && (busy || full);
    e.st = st;
    e.er = m_err;
    q.push_back(e);
    tq.push_back(tag);
    if (r) begin
      for (int w = 0; w < 2; w++) if (we[w] && wa[w] != 0) m_mem[wa[w]] = wd[w];
      for (int k = 1; k < NREG; k++) begin
        int n;
        if (fl) n = 0;
        else begin
          n = m_pend[k] + ((iv && !st && iw && ird == k) ? 1 : 0) - ret[k];
          if (n < 0) begin n = 0; m_err = 1; end
        end
        m_pend[k] = n;
      end
    end
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  // Monitor: compare the oldest expected response with what the DUT presents
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        t = tq.pop_front();
        chk({t, ".rd0"},  rd_data[31:0],  e.d0);
        chk({t, ".rd1"},  rd_data[63:32], e.d1);
        chk({t, ".stall"}, 32'(stall), 32'(e.st));
        chk({t, ".err"},   32'(err),   32'(e.er));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int        wa[2], ra[2];
    bit [1:0]  we;
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0; rd_used = '0;
    issue_valid = 0; issue_wen = 0; issue_rd = '0; flush = 0;

    cyc("reset", 0, 2'b00, 0, 0, 0, 0, 5, 3, 2'b11, 0, 0, 0, 0);
    idle("post_reset");
    cyc("bypass5", 1, 2'b01, 5, 0, 32'hDEADBEEF, 0, 5, 0, 2'b00, 0, 0, 0, 0);
    cyc("stored5", 1, 2'b00, 0, 0, 0, 0, 5, 5, 2'b00, 0, 0, 0, 0);
    cyc("wr_x0",   1, 2'b10, 0, 0, 0, 32'h1234, 0, 5, 2'b00, 0, 0, 0, 0);
    cyc("issue7",  1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 7, 0);
    cyc("raw7",    1, 2'b00, 0, 0, 0, 0, 7, 0, 2'b01, 1, 0, 0, 0);
    cyc("wb7",     1, 2'b01, 7, 0, 32'h55, 0, 7, 0, 2'b01, 1, 0, 0, 0);
    cyc("after7",  1, 2'b00, 0, 0, 0, 0, 0, 7, 2'b10, 1, 0, 0, 0);

    repeat (3) cyc("waw3", 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3, 0);
    cyc("full3",     1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3, 0);
    cyc("full3_ret", 1, 2'b10, 0, 3, 0, 32'h33, 0, 0, 2'b00, 1, 1, 3, 0);
    cyc("still3",    1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 3, 0);
    repeat (3) cyc("drain3", 1, 2'b01, 3, 0, 32'h3, 0, 3, 0, 2'b00, 0, 0, 0, 0);
    cyc("free3",     1, 2'b00, 0, 0, 0, 0, 3, 0, 2'b01, 1, 0, 0, 0);

    repeat (2) cyc("issue9", 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 9, 0);
    cyc("dual9",  1, 2'b11, 9, 9, 32'hA, 32'hB, 9, 9, 2'b11, 1, 0, 0, 0);
    cyc("after9", 1, 2'b00, 0, 0, 0, 0, 9, 9, 2'b11, 1, 0, 0, 0);

    cyc("under4", 1, 2'b01, 4, 0, 32'h44, 0, 4, 0, 2'b00, 0, 0, 0, 0);
    idle("err_set");
    idle("err_hold");

    repeat (2) cyc("issue2", 1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2, 0);
    cyc("issue6",  1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 6, 0);
    cyc("busy26",  1, 2'b00, 0, 0, 0, 0, 2, 6, 2'b11, 1, 0, 0, 0);
    cyc("flush",   1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 2, 1);
    cyc("postfl",  1, 2'b00, 0, 0, 0, 0, 2, 6, 2'b11, 1, 0, 0, 0);

    cyc("issue8",  1, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 8, 0);
    cyc("midrst",  0, 2'b00, 0, 0, 0, 0, 8, 5, 2'b01, 1, 0, 0, 0);
    cyc("postrst", 1, 2'b00, 0, 0, 0, 0, 8, 7, 2'b11, 1, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      for (int w = 0; w < 2; w++) begin
        wa[w] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
        we[w] = ($urandom_range(0, 2) == 0) && (m_pend[wa[w]] > 0 || $urandom_range(0, 19) == 0);
        ra[w] = $urandom_range(0, 7);
      end
      cyc("rand", $urandom_range(0, 99) != 0, we, wa[0], wa[1], $urandom, $urandom,
          ra[0], ra[1], 2'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
          $urandom_range(0, 7), $urandom_range(0, 29) == 0);
    end

    idle("tail");
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
